// File: rtl/mem_port_arbiter_module_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_module_if
// Bundles the three sides of the shared memory port arbiter:
//   I-cache refill side : i_read, i_address -> i_readdata, i_busywait
//   D-cache side        : d_read, d_write, d_address, d_writedata
//                         -> d_readdata, d_busywait
//   main memory side    : mem_read, mem_write, mem_address, mem_writedata
//                         <- mem_readdata, mem_busywait
// Modports:
//   slave  : the arbiter's view (requests and memory responses come in)
//   master : the environment's view (caches plus memory)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_module_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128
);
  // I-cache refill path
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [DATA_WIDTH-1:0] i_readdata;
  logic                  i_busywait;

  // D-cache refill / write-back path
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [DATA_WIDTH-1:0] d_writedata;
  logic [DATA_WIDTH-1:0] d_readdata;
  logic                  d_busywait;

  // Main memory port
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_writedata;
  logic [DATA_WIDTH-1:0] mem_readdata;
  logic                  mem_busywait;

  modport slave (
    input  i_read, i_address,
    output i_readdata, i_busywait,
    input  d_read, d_write, d_address, d_writedata,
    output d_readdata, d_busywait,
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait
  );

  modport master (
    output i_read, i_address,
    input  i_readdata, i_busywait,
    output d_read, d_write, d_address, d_writedata,
    input  d_readdata, d_busywait,
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait
  );
endinterface

// File: rtl/mem_port_arbiter_module.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_module
// Shares one main-memory port between the I-cache refill path and the
// D-cache refill/write-back path. D has priority; once MAX_D_RUN consecutive
// D grants have been made while I was waiting, a pending I request wins.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : mem_port_arbiter_module_if.slave (I side, D side, memory side)
// Transfer shape: IDLE -> ACCESS (first edge ignored, completes on the first
// later edge with mem_busywait low) -> DONE (one cycle, owner released) ->
// IDLE. There is never a grant straight out of DONE.
// ---------------------------------------------------------------------------
module mem_port_arbiter_module #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128,
  parameter int MAX_D_RUN  = 4
) (
  input logic                    clk,
  input logic                    rst,
  mem_port_arbiter_module_if.slave bus
);

  localparam int RUN_WIDTH = $clog2(MAX_D_RUN + 1);
  localparam logic [RUN_WIDTH-1:0] RUN_ZERO = {RUN_WIDTH{1'b0}};
  localparam logic [RUN_WIDTH-1:0] RUN_ONE  = RUN_WIDTH'(1);
  localparam logic [RUN_WIDTH-1:0] RUN_MAX  = RUN_WIDTH'(MAX_D_RUN);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_D = 1'b0,
    OWNER_I = 1'b1
  } owner_t;

  state_t                state_r;
  owner_t                owner_r;
  logic [RUN_WIDTH-1:0]  d_run_r;
  logic                  first_edge_r;
  logic                  mem_read_r;
  logic                  mem_write_r;
  logic [ADDR_WIDTH-1:0] mem_address_r;
  logic [DATA_WIDTH-1:0] mem_writedata_r;
  logic [DATA_WIDTH-1:0] i_readdata_r;
  logic [DATA_WIDTH-1:0] d_readdata_r;

  logic                  req_i_s;
  logic                  req_d_s;
  logic                  run_full_s;
  logic                  grant_i_s;
  logic [RUN_WIDTH-1:0]  d_run_next_s;
  logic                  i_done_s;
  logic                  d_done_s;

  assign req_i_s    = bus.i_read;
  assign req_d_s    = bus.d_read | bus.d_write;
  assign run_full_s = (d_run_r == RUN_MAX);
  assign i_done_s   = (state_r == ST_DONE) && (owner_r == OWNER_I);
  assign d_done_s   = (state_r == ST_DONE) && (owner_r == OWNER_D);

  // Grant selection: D wins unless I has waited through a full D run.
  always_comb begin
    grant_i_s = 1'b0;
    if (req_d_s && !(req_i_s && run_full_s)) begin
      grant_i_s = 1'b0;
    end else begin
      grant_i_s = req_i_s;
    end
  end

  // Next value of the consecutive-D-grant counter, applied only on a grant.
  always_comb begin
    d_run_next_s = RUN_ZERO;
    if (grant_i_s) begin
      d_run_next_s = RUN_ZERO;
    end else if (req_i_s) begin
      // D granted over a waiting I: count it, holding at the limit.
      if (run_full_s) begin
        d_run_next_s = d_run_r;
      end else begin
        d_run_next_s = d_run_r + RUN_ONE;
      end
    end else begin
      d_run_next_s = RUN_ZERO;
    end
  end

  // Transfer FSM with registered memory commands and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      owner_r         <= OWNER_D;
      d_run_r         <= RUN_ZERO;
      first_edge_r    <= 1'b0;
      mem_read_r      <= 1'b0;
      mem_write_r     <= 1'b0;
      mem_address_r   <= {ADDR_WIDTH{1'b0}};
      mem_writedata_r <= {DATA_WIDTH{1'b0}};
      i_readdata_r    <= {DATA_WIDTH{1'b0}};
      d_readdata_r    <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_i_s || req_d_s) begin
            state_r      <= ST_ACCESS;
            first_edge_r <= 1'b1;
            d_run_r      <= d_run_next_s;
            if (grant_i_s) begin
              owner_r       <= OWNER_I;
              mem_address_r <= bus.i_address;
              mem_read_r    <= 1'b1;
              mem_write_r   <= 1'b0;
            end else begin
              // A simultaneous read and write from D performs the write.
              owner_r         <= OWNER_D;
              mem_address_r   <= bus.d_address;
              mem_writedata_r <= bus.d_writedata;
              mem_read_r      <= ~bus.d_write;
              mem_write_r     <= bus.d_write;
            end
          end
        end
        ST_ACCESS: begin
          // Memory busywait is not trusted on the edge right after the command.
          if (first_edge_r) begin
            first_edge_r <= 1'b0;
          end else if (!bus.mem_busywait) begin
            state_r     <= ST_DONE;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            if (mem_read_r) begin
              if (owner_r == OWNER_I) begin
                i_readdata_r <= bus.mem_readdata;
              end else begin
                d_readdata_r <= bus.mem_readdata;
              end
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r      <= ST_IDLE;
          first_edge_r <= 1'b0;
          mem_read_r   <= 1'b0;
          mem_write_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_read      = mem_read_r;
  assign bus.mem_write     = mem_write_r;
  assign bus.mem_address   = mem_address_r;
  assign bus.mem_writedata = mem_writedata_r;
  assign bus.i_readdata    = i_readdata_r;
  assign bus.d_readdata    = d_readdata_r;
  // Stalls are combinational so a requester sees its release in the DONE cycle.
  assign bus.i_busywait    = bus.i_read & ~i_done_s;
  assign bus.d_busywait    = req_d_s & ~d_done_s;

  mem_port_arbiter_module_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read_r),
    .mem_write (mem_write_r),
    .in_access (state_r == ST_ACCESS),
    .in_done   (state_r == ST_DONE)
  );

endmodule

// ---------------------------------------------------------------------------
// mem_port_arbiter_module_chk
// Protocol properties of the arbiter's memory port.
// Ports: clk, rst, mem_read, mem_write, in_access, in_done (all inputs).
// ---------------------------------------------------------------------------
module mem_port_arbiter_module_chk (
  input logic clk,
  input logic rst,
  input logic mem_read,
  input logic mem_write,
  input logic in_access,
  input logic in_done
);

  a_single_cmd: assert property (@(posedge clk) disable iff (rst)
    !(mem_read && mem_write));

  a_cmd_in_access: assert property (@(posedge clk) disable iff (rst)
    (mem_read || mem_write) |-> in_access);

  a_done_one_cycle: assert property (@(posedge clk) disable iff (rst)
    in_done |=> !in_done);

  a_done_after_access: assert property (@(posedge clk) disable iff (rst)
    in_done |-> $past(in_access));

endmodule
